// File: rtl/cyp2sdram.sv
// cyp2sdram: bridge from the FX2 (CY68013) synchronous slave-FIFO OUT endpoint (EP2) to an SDRAM
// write-request port.
//
// A registered read FSM drives the FX2 strobes and drains EP2 while data is present and the
// internal buffer has room. Each captured 16-bit word is queued. Words leave the queue on a
// valid/ready write port, tagged with a free-running, wrapping word address.
//
// Ports:
//   cyp_clk       in   sole clock (FX2 IFCLK domain)
//   rst_n         in   asynchronous active-low reset
//   usb_clk       out  IFCLK to the FX2, a copy of cyp_clk
//   usb_fifoaddr  out  FIFO select, fixed to EP2 (2'b00)
//   usb_slcs      out  chip select, active low; low from the first edge after reset
//   usb_sloe      out  FX2 output enable, active low
//   usb_slrd      out  read strobe, active low
//   usb_slwr      out  write strobe, active low; held inactive
//   usb_fd_i      in   FX2 data bus, input half
//   usb_fd_o      out  FX2 data bus, output half; held 0
//   usb_fd_oe     out  bus drive enable; held 0
//   usb_flaga     in   EP2 not-empty
//   usb_flagb/c   in   unused
//   pa0           out  FX2 PA0; held 1
//   wr_data       out  buffered word at the queue head
//   wr_addr       out  word address of wr_data
//   wr_valid      out  queue not empty
//   wr_ready      in   controller accepts wr_data/wr_addr when high with wr_valid
module cyp2sdram #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 22
) (
  input  logic              cyp_clk,
  input  logic              rst_n,
  output logic              usb_clk,
  output logic [1:0]        usb_fifoaddr,
  output logic              usb_slcs,
  output logic              usb_sloe,
  output logic              usb_slrd,
  output logic              usb_slwr,
  input  logic [15:0]       usb_fd_i,
  output logic [15:0]       usb_fd_o,
  output logic              usb_fd_oe,
  input  logic              usb_flaga,
  input  logic              usb_flagb,
  input  logic              usb_flagc,
  output logic              pa0,
  output logic [15:0]       wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_valid,
  input  logic              wr_ready
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] TwoC   = CntW'(2);

  typedef enum logic [1:0] {StIdle, StOe, StRead} state_e;

  state_e            state_q;
  logic              sloe_q;
  logic              slrd_q;
  logic              slcs_q;
  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   count_d;
  logic [ADDR_W-1:0] addr_q;

  logic [CntW-1:0]   free_slots;
  logic              can_read;
  logic              push;
  logic              pop;
  logic              unused_flags;

  assign unused_flags = usb_flagb ^ usb_flagc;

  // Static FX2 pins.
  assign usb_clk      = cyp_clk;
  assign usb_fifoaddr = 2'b00;
  assign usb_slwr     = 1'b1;
  assign usb_fd_o     = 16'h0000;
  assign usb_fd_oe    = 1'b0;
  assign pa0          = 1'b1;

  assign usb_slcs = slcs_q;
  assign usb_sloe = sloe_q;
  assign usb_slrd = slrd_q;

  assign free_slots = DepthC - count_q;
  assign can_read   = usb_flaga && (free_slots >= TwoC);

  // The FX2 only presents a word when its flag says data is there, so a low flag with the strobe
  // still asserted (one cycle of strobe latency) must not be captured.
  assign push = !slrd_q && usb_flaga;
  assign pop  = (count_q != '0) && wr_ready;

  assign wr_valid = (count_q != '0);
  assign wr_data  = mem_q[rd_ptr_q];
  assign wr_addr  = addr_q;

  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      slcs_q <= 1'b1;
    end else begin
      slcs_q <= 1'b0;
    end
  end

  // Read FSM with registered strobes. Leaving READ at free_slots <= 2 (evaluated before this
  // edge's push) leaves room for the word captured on the same edge, so the queue never overflows.
  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sloe_q  <= 1'b1;
      slrd_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (can_read) begin
            state_q <= StOe;
            sloe_q  <= 1'b0;
          end
        end
        StOe: begin
          if (can_read) begin
            state_q <= StRead;
            slrd_q  <= 1'b0;
          end else begin
            state_q <= StIdle;
            sloe_q  <= 1'b1;
          end
        end
        StRead: begin
          if (!usb_flaga || (free_slots <= TwoC)) begin
            state_q <= StIdle;
            sloe_q  <= 1'b1;
            slrd_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          sloe_q  <= 1'b1;
          slrd_q  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Word buffer; pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= usb_fd_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  // Free-running word address; wraps from all-ones to zero.
  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (pop) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_cyp2sdram.sv
// Self-checking bench for cyp2sdram. An FX2 model serves an incrementing word stream; a queue-based
// scoreboard predicts occupancy, data order and addresses. A second instance with a 3-bit address
// exercises address wrap.
module tb_cyp2sdram;

  localparam int unsigned Depth = 8;

  logic        cyp_clk = 1'b0;
  logic        rst_n;
  logic        usb_clk;
  logic [1:0]  usb_fifoaddr;
  logic        usb_slcs, usb_sloe, usb_slrd, usb_slwr;
  logic [15:0] usb_fd_i;
  logic [15:0] usb_fd_o;
  logic        usb_fd_oe;
  logic        usb_flaga;
  logic        pa0;
  logic [15:0] wr_data;
  logic [21:0] wr_addr;
  logic        wr_valid;
  logic        wr_ready;

  logic        s_clk, s_slcs, s_sloe, s_slrd, s_slwr, s_fd_oe, s_pa0, s_valid;
  logic [1:0]  s_fifoaddr;
  logic [15:0] s_fd_o, s_data;
  logic [2:0]  s_addr;

  always #5 cyp_clk = ~cyp_clk;

  cyp2sdram #(.FIFO_DEPTH(Depth), .ADDR_W(22)) dut (
    .cyp_clk(cyp_clk), .rst_n(rst_n), .usb_clk(usb_clk), .usb_fifoaddr(usb_fifoaddr),
    .usb_slcs(usb_slcs), .usb_sloe(usb_sloe), .usb_slrd(usb_slrd), .usb_slwr(usb_slwr),
    .usb_fd_i(usb_fd_i), .usb_fd_o(usb_fd_o), .usb_fd_oe(usb_fd_oe), .usb_flaga(usb_flaga),
    .usb_flagb(1'b0), .usb_flagc(1'b0), .pa0(pa0), .wr_data(wr_data), .wr_addr(wr_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready)
  );

  cyp2sdram #(.FIFO_DEPTH(Depth), .ADDR_W(3)) dut_small (
    .cyp_clk(cyp_clk), .rst_n(rst_n), .usb_clk(s_clk), .usb_fifoaddr(s_fifoaddr),
    .usb_slcs(s_slcs), .usb_sloe(s_sloe), .usb_slrd(s_slrd), .usb_slwr(s_slwr),
    .usb_fd_i(usb_fd_i), .usb_fd_o(s_fd_o), .usb_fd_oe(s_fd_oe), .usb_flaga(usb_flaga),
    .usb_flagb(1'b1), .usb_flagc(1'b1), .pa0(s_pa0), .wr_data(s_data), .wr_addr(s_addr),
    .wr_valid(s_valid), .wr_ready(wr_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int fx_val = 0;
  int limit  = 0;
  int q[$];
  int occ = 0;
  int addr_cnt = 0;
  int delivered = 0;
  int cyc = 0;
  int phase_start = 0;
  int rise_cyc = 0;
  bit cap_pend = 0, pop_pend = 0;
  bit have_prev = 0, prev_slrd = 1, prev_flaga = 0;
  int prev_occ = 0;
  bit check_gap = 0, gap_armed = 0;
  bit rand_mode = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: retire the previous edge into the model, compare, then drive new inputs.
  task automatic cycle();
    int pc;
    bit drop, rdy;
    @(negedge cyp_clk);
    cyc++;
    if (cap_pend) begin
      q.push_back(fx_val);
      fx_val++;
    end
    if (pop_pend) begin
      void'(q.pop_front());
      addr_cnt++;
      delivered++;
    end
    occ = q.size();

    check_eq("wr_valid", wr_valid, occ > 0);
    check_eq("small_valid", s_valid, occ > 0);
    check_eq("no_overflow", occ <= Depth, 1);
    if (occ > 0) begin
      check_eq("wr_data", wr_data, q[0] & 16'hffff);
      check_eq("wr_addr", wr_addr, addr_cnt % (1 << 22));
      check_eq("wr_addr_wrap", s_addr, addr_cnt % 8);
    end
    if (have_prev) begin
      if (!prev_flaga) begin
        check_eq("slrd_after_flag_low", usb_slrd, 1);
        check_eq("sloe_after_flag_low", usb_sloe, 1);
      end
      if (prev_occ >= Depth - 1 || (prev_occ >= Depth - 2 && !prev_slrd)) begin
        check_eq("slrd_threshold", usb_slrd, 1);
      end
    end

    pc = cyc - phase_start;
    if (rand_mode) begin
      drop = ($urandom % 16) == 0;
      rdy  = ($urandom % 4) != 0;
    end else begin
      drop = (pc >= 150 && pc < 160);
      rdy  = !(pc >= 60 && pc < 80);
    end
    usb_fd_i  = fx_val[15:0];
    usb_flaga = (fx_val < limit) && !drop;
    wr_ready  = rdy;

    if (check_gap && usb_flaga && !prev_flaga) begin
      rise_cyc  = cyc;
      gap_armed = 1;
    end
    cap_pend = !usb_slrd && usb_flaga;
    pop_pend = wr_valid && wr_ready;
    if (cap_pend && gap_armed) begin
      check_eq("startup_gap", cyc - rise_cyc, 2);
      gap_armed = 0;
    end
    prev_occ   = occ;
    prev_slrd  = usb_slrd;
    prev_flaga = usb_flaga;
    have_prev  = 1;
  endtask

  initial begin
    int budget;
    rst_n     = 1'b0;
    usb_fd_i  = '0;
    usb_flaga = 1'b0;
    wr_ready  = 1'b1;
    #12;
    check_eq("rst_slcs", usb_slcs, 1);
    check_eq("rst_sloe", usb_sloe, 1);
    check_eq("rst_slrd", usb_slrd, 1);
    check_eq("rst_wr_valid", wr_valid, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    @(negedge cyp_clk);
    rst_n = 1'b1;
    cycle();
    check_eq("slcs_low", usb_slcs, 0);
    check_eq("fifoaddr", usb_fifoaddr, 0);
    check_eq("slwr", usb_slwr, 1);
    check_eq("fd_oe", usb_fd_oe, 0);
    check_eq("fd_o", usb_fd_o, 0);
    check_eq("pa0", pa0, 1);
    check_eq("usb_clk", usb_clk, cyp_clk);
    cycle();

    // Phase 1: 256-word stream with a 20-cycle stall and a 10-cycle flag drop.
    limit       = 256;
    check_gap   = 1;
    phase_start = cyc;
    budget = 0;
    while (!(delivered == 256 && occ == 0) && budget < 2000) begin
      cycle();
      budget++;
    end
    check_eq("phase1_done_in_budget", budget < 2000, 1);
    repeat (3) cycle();
    check_eq("phase1_words", delivered, 256);
    check_eq("phase1_end_slrd", usb_slrd, 1);
    check_eq("phase1_end_valid", wr_valid, 0);
    check_eq("phase1_end_addr", wr_addr, 256);
    check_eq("phase1_end_wrap_addr", s_addr, 0);

    // Phase 2: random backpressure and flag drops, with a reset pulse mid-stream.
    check_gap = 0;
    rand_mode = 1;
    limit     = fx_val + 300;
    repeat (100) cycle();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", wr_valid, 0);
    check_eq("midrst_addr", wr_addr, 0);
    check_eq("midrst_slrd", usb_slrd, 1);
    check_eq("midrst_sloe", usb_sloe, 1);
    check_eq("midrst_slcs", usb_slcs, 1);
    q.delete();
    occ       = 0;
    addr_cnt  = 0;
    delivered = 0;
    cap_pend  = 0;
    pop_pend  = 0;
    have_prev = 0;
    repeat (2) @(negedge cyp_clk);
    rst_n = 1'b1;
    budget = 0;
    while (!(fx_val >= limit && occ == 0) && budget < 5000) begin
      cycle();
      budget++;
    end
    check_eq("phase2_done_in_budget", budget < 5000, 1);
    check_eq("phase2_addr_matches_count", wr_addr, delivered);
    check_eq("phase2_end_valid", wr_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
